// File: rtl/regfile_pkg.sv
// Shared register-file geometry used by the processor, the register file and the benches.
package regfile_pkg;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_register32.sv
// One register-file entry: a WIDTH-bit flop with write enable and an asynchronous clear.
module register32 #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Clear dominates enable, so a write in flight when clear rises is lost.
  always_comb begin
    value_d = value_q;
    if (enable) value_d = d_i;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) value_q <= '0;
    else       value_q <= value_d;
  end

  assign q_o = value_q;

endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file; register 0 is hardwired to zero and has no storage.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH = regfile_pkg::WIDTH,
  parameter int DEPTH = regfile_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB
);

  logic [DEPTH-1:1] writeSel;
  logic [WIDTH-1:0] regs [DEPTH];

  // One-hot write decode; index 0 never selects anything.
  always_comb begin
    writeSel = '0;
    for (int i = 1; i < DEPTH; i++) begin
      writeSel[i] = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(i));
    end
  end

  assign regs[ZERO_REG] = '0;

  for (genvar g = 1; g < DEPTH; g++) begin : gen_regs
    register32 #(.W(WIDTH)) u_reg (
      .clock  (clock),
      .clear  (ctrl_reset),
      .enable (writeSel[g]),
      .d_i    (data_writeReg),
      .q_o    (regs[g])
    );
  end

  // Full 32:1 selection per port with a zero default, so no index can yield X.
  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ctrl_readRegA == ADDR_W'(i)) data_readRegA = regs[i];
      if (ctrl_readRegB == ADDR_W'(i)) data_readRegB = regs[i];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected reads from an array model, a negedge monitor checks them.
module tb_regfile;
  import regfile_pkg::*;

  logic              clock = 1'b0;
  logic              ctrl_reset;
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [WIDTH-1:0]  data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [WIDTH-1:0]  data_readRegA;
  logic [WIDTH-1:0]  data_readRegB;

  regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  always #5 clock = ~clock;

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] expA [$];
  logic [WIDTH-1:0] expB [$];
  string            expName [$];
  bit               checkValid = 1'b0;
  int               vectors = 0;
  int               miscompares = 0;

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Queue what the read ports must show given the model as it stands now.
  task automatic expectRead(input string nm);
    expA.push_back(model[ctrl_readRegA]);
    expB.push_back(model[ctrl_readRegB]);
    expName.push_back(nm);
    checkValid = 1'b1;
  endtask

  // Drive one cycle's inputs just after the rising edge; the write lands at the following edge.
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wr,
                               input logic [WIDTH-1:0] wd,
                               input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                               input bit chk, input string nm);
    @(posedge clock);
    #1;
    ctrl_writeEnable = we;
    ctrl_writeReg    = wr;
    data_writeReg    = wd;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
    checkValid       = 1'b0;
    if (chk) expectRead(nm);
    if (we && wr != 0 && !ctrl_reset) model[wr] = wd;
  endtask

  task automatic checkOutput();
    logic [WIDTH-1:0] a, b;
    string nm;
    if (expA.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: check requested with empty queue");
      return;
    end
    a  = expA.pop_front();
    b  = expB.pop_front();
    nm = expName.pop_front();
    vectors += 2;
    if (data_readRegA !== a) begin
      miscompares++;
      $display("[TB] FAIL %s portA idx=%0d got=%h want=%h", nm, ctrl_readRegA, data_readRegA, a);
    end
    if (data_readRegB !== b) begin
      miscompares++;
      $display("[TB] FAIL %s portB idx=%0d got=%h want=%h", nm, ctrl_readRegB, data_readRegB, b);
    end
  endtask

  always @(negedge clock) begin
    if (checkValid) checkOutput();
  end

  initial begin
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readRegA    = 5'd1;
    ctrl_readRegB    = 5'd31;
    clearModel();

    applyStimulus(1'b1, 5'd4, 32'h1234_5678, 5'd4, 5'd31, 1'b1, "reset_state");
    applyStimulus(1'b0, 5'd0, '0, 5'd4, 5'd0, 1'b1, "reset_hold");
    #1 ctrl_reset = 1'b0;

    applyStimulus(1'b0, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7, 1'b0, "");
    applyStimulus(1'b0, 5'd0, '0, 5'd7, 5'd7, 1'b1, "write_enable_low");

    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, ADDR_W'(i), WIDTH'(i * 16 + 1), 5'd0, 5'd0, 1'b0, "");
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 5'd0, '0, ADDR_W'(i), ADDR_W'(i), 1'b1, "sweep");

    applyStimulus(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd0, 5'd0, 1'b0, "");
    applyStimulus(1'b1, 5'd12, 32'h5A5A_5A5A, 5'd0, 5'd0, 1'b0, "");
    applyStimulus(1'b0, 5'd0, '0, 5'd3, 5'd12, 1'b1, "dual_read");
    applyStimulus(1'b0, 5'd0, '0, 5'd12, 5'd3, 1'b1, "dual_read_swap");

    applyStimulus(1'b1, 5'd9, 32'h0000_1111, 5'd0, 5'd0, 1'b0, "");
    applyStimulus(1'b1, 5'd9, 32'h0000_2222, 5'd9, 5'd9, 1'b1, "same_cycle_before");
    applyStimulus(1'b0, 5'd0, '0, 5'd9, 5'd9, 1'b1, "same_cycle_after");

    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, "");
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, "zero_reg");

    for (int n = 0; n < 300; n++)
      applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom), WIDTH'($urandom),
                    ADDR_W'($urandom), ADDR_W'($urandom), 1'b1, "random");

    // Fill every register with nonzero data, then pulse reset between edges.
    for (int i = 1; i < DEPTH; i++)
      applyStimulus(1'b1, ADDR_W'(i), WIDTH'($urandom) | 32'h1, 5'd0, 5'd0, 1'b0, "");
    applyStimulus(1'b0, 5'd0, '0, 5'd5, 5'd31, 1'b1, "prefill");
    applyStimulus(1'b1, 5'd5, 32'h0000_0077, 5'd5, 5'd31, 1'b0, "");
    #2;
    ctrl_reset = 1'b1;
    clearModel();
    expectRead("async_reset_immediate");
    applyStimulus(1'b1, 5'd5, 32'h0000_0077, 5'd5, 5'd1, 1'b1, "write_during_reset");
    applyStimulus(1'b0, 5'd0, '0, 5'd5, 5'd1, 1'b1, "after_reset_edge");
    #1 ctrl_reset = 1'b0;
    applyStimulus(1'b1, 5'd6, 32'h0000_0066, 5'd6, 5'd5, 1'b1, "post_reset_before");
    applyStimulus(1'b0, 5'd0, '0, 5'd6, 5'd5, 1'b1, "post_reset_first_write");

    @(posedge clock);
    #1 checkValid = 1'b0;
    @(negedge clock);
    #1;
    if (expA.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", expA.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
